bird_motion_ctrl: RTL and testbench

// - Parametrised vertical-motion controller for the player sprite ("bird").
// - Sits between the keycode source (keycode[7:0]) and the sprite/collision logic.
// - Models signed fixed-point velocity and gravity, and accepts one flap per key press.
// - Runs the game-life FSM: idle, fly, dying and dead.
// - Outputs the sprite box and the gameover flag.

---
 rtl/bird_pkg.sv | 25 ++
 rtl/key_edge_det.sv | 31 +++
 rtl/bird_motion_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bird_motion_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bird_pkg.sv
// Shared types and constants for the bird vertical-motion controller.
// The widths follow the fixed-point layout: 10 integer pixel bits plus FRAC_BITS fraction.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLY   = 2'd1,
        DYING = 2'd2,
        DEAD  = 2'd3
    } bird_state_t;

    localparam int PIX_W         = 10;
    localparam int FRAC_BITS_DEF = 4;
    localparam int VEL_OUT_W_DEF = PIX_W + FRAC_BITS_DEF;
    localparam int FIX_W_DEF     = PIX_W + FRAC_BITS_DEF + 1;

    localparam logic [7:0] KEY_W_CODE      = 8'h1A;
    localparam logic [7:0] KEY_W_MECH_CODE = 8'hCC;

    // One spare sign bit above the pixel range keeps pos+vel from wrapping before the clamp.
    function automatic int fix_width(input int frac_bits);
        return PIX_W + frac_bits + 1;
    endfunction

endpackage

// File: rtl/key_edge_det.sv
// Turns a level keycode into a one-frame flap request on the first frame either flap code is seen.
// History only advances while enabled, so a pause freezes the edge detector as well.
module key_edge_det
    import bird_pkg::*;
#(
    parameter logic [7:0] CODE_A = KEY_W_CODE,
    parameter logic [7:0] CODE_B = KEY_W_MECH_CODE
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [7:0] i_key,
    output logic       o_edge
);

    logic w_match;
    logic r_prev_match;

    assign w_match = (i_key == CODE_A) || (i_key == CODE_B);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_match <= 1'b0;
        end else if (i_en) begin
            r_prev_match <= w_match;
        end
    end

    assign o_edge = i_en && w_match && !r_prev_match;

endmodule

// File: rtl/bird_motion_ctrl.sv
// Vertical motion and game-life FSM for the player sprite: signed fixed-point integrator,
// ceiling/floor clamping, one flap per key press, and IDLE/FLY/DYING/DEAD sequencing.
module bird_motion_ctrl
    import bird_pkg::*;
#(
    parameter int         X_START   = 100,
    parameter int         Y_START   = 240,
    parameter int         Y_MIN     = 0,
    parameter int         Y_MAX     = 479,
    parameter int         BIRD_W    = 86,
    parameter int         BIRD_H    = 26,
    parameter int         FRAC_BITS = FRAC_BITS_DEF,
    parameter int         GRAVITY   = 8,
    parameter int         JUMP_VEL  = -96,
    parameter int         VMAX_DOWN = 128,
    parameter logic [7:0] KEY_A     = KEY_W_CODE,
    parameter logic [7:0] KEY_B     = KEY_W_MECH_CODE
) (
    input  logic                               frame_clk,
    input  logic                               Reset,
    input  logic                               rdy,
    input  logic [7:0]                         key,
    input  logic                               collide,
    output logic [9:0]                         BirdX,
    output logic [9:0]                         BirdY,
    output logic [9:0]                         BirdW,
    output logic [9:0]                         BirdH,
    output logic signed [PIX_W+FRAC_BITS-1:0]  vel_y,
    output bird_state_t                        state,
    output logic                               flap_pulse,
    output logic                               gameover
);

    localparam int FIX_W = fix_width(FRAC_BITS);
    localparam int VEL_W = PIX_W + FRAC_BITS;
    localparam int ONE_PX = 2 ** FRAC_BITS;

    localparam logic signed [FIX_W-1:0] C_POS_START = FIX_W'(Y_START * ONE_PX);
    localparam logic signed [FIX_W-1:0] C_POS_CEIL  = FIX_W'(Y_MIN * ONE_PX);
    localparam logic signed [FIX_W-1:0] C_POS_FLOOR = FIX_W'((Y_MAX - BIRD_H) * ONE_PX);
    localparam logic signed [FIX_W-1:0] C_GRAVITY   = FIX_W'(GRAVITY);
    localparam logic signed [FIX_W-1:0] C_JUMP_VEL  = FIX_W'(JUMP_VEL);
    localparam logic signed [FIX_W-1:0] C_VMAX_DOWN = FIX_W'(VMAX_DOWN);

    bird_state_t             r_state;
    logic signed [FIX_W-1:0] r_pos;
    logic signed [FIX_W-1:0] r_vel;
    logic                    r_flap_pulse;
    logic                    r_gameover;

    bird_state_t             w_state_nxt;
    logic signed [FIX_W-1:0] w_pos_nxt;
    logic signed [FIX_W-1:0] w_vel_nxt;
    logic                    w_flap_nxt;
    logic                    w_gameover_nxt;

    logic                    w_flap_edge;
    logic signed [FIX_W-1:0] w_pos_sum;
    logic signed [FIX_W-1:0] w_vel_grav;
    logic signed [FIX_W-1:0] w_vel_fall;
    logic                    w_floor_hit;
    logic                    w_ceil_hit;
    logic                    w_unused;

    key_edge_det #(
        .CODE_A (KEY_A),
        .CODE_B (KEY_B)
    ) u_key_edge_det (
        .i_clk  (frame_clk),
        .i_rst  (Reset),
        .i_en   (rdy),
        .i_key  (key),
        .o_edge (w_flap_edge)
    );

    // Position integrates the registered velocity, so it trails a velocity change by one frame.
    assign w_pos_sum   = r_pos + r_vel;
    assign w_vel_grav  = r_vel + C_GRAVITY;
    assign w_vel_fall  = (w_vel_grav > C_VMAX_DOWN) ? C_VMAX_DOWN : w_vel_grav;
    assign w_floor_hit = (w_pos_sum >= C_POS_FLOOR);
    assign w_ceil_hit  = (w_pos_sum < C_POS_CEIL);

    // rdy is a hold-enable rather than a handshake: while low every register keeps its value
    // and only the flap strobe is forced low.
    always_comb begin
        w_state_nxt    = r_state;
        w_pos_nxt      = r_pos;
        w_vel_nxt      = r_vel;
        w_flap_nxt     = 1'b0;
        w_gameover_nxt = r_gameover;

        if (rdy) begin
            unique case (r_state)
                IDLE: begin
                    w_pos_nxt = C_POS_START;
                    w_vel_nxt = '0;
                    if (w_flap_edge) begin
                        w_state_nxt = FLY;
                        w_vel_nxt   = C_JUMP_VEL;
                        w_flap_nxt  = 1'b1;
                    end
                end

                FLY, DYING: begin
                    w_pos_nxt = w_pos_sum;
                    if ((r_state == FLY) && w_flap_edge && !collide) begin
                        w_vel_nxt  = C_JUMP_VEL;
                        w_flap_nxt = 1'b1;
                    end else begin
                        w_vel_nxt = w_vel_fall;
                    end

                    if ((r_state == FLY) && collide) begin
                        w_state_nxt = DYING;
                    end

                    // Floor contact wins over a flap or a collision in the same frame.
                    if (w_floor_hit) begin
                        w_pos_nxt      = C_POS_FLOOR;
                        w_vel_nxt      = '0;
                        w_state_nxt    = DEAD;
                        w_flap_nxt     = 1'b0;
                        w_gameover_nxt = 1'b1;
                    end else if (w_ceil_hit) begin
                        w_pos_nxt = C_POS_CEIL;
                        w_vel_nxt = '0;
                    end
                end

                DEAD: begin
                    w_gameover_nxt = 1'b1;
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_pos        <= C_POS_START;
            r_vel        <= '0;
            r_flap_pulse <= 1'b0;
            r_gameover   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pos        <= w_pos_nxt;
            r_vel        <= w_vel_nxt;
            r_flap_pulse <= w_flap_nxt;
            r_gameover   <= w_gameover_nxt;
        end
    end

    // After clamping r_pos is never negative, so the pixel slice needs no sign handling.
    assign BirdX      = 10'(X_START);
    assign BirdY      = r_pos[FRAC_BITS +: PIX_W];
    assign BirdW      = 10'(BIRD_W);
    assign BirdH      = 10'(BIRD_H);
    assign vel_y      = r_vel[VEL_W-1:0];
    assign state      = r_state;
    assign flap_pulse = r_flap_pulse;
    assign gameover   = r_gameover;

    assign w_unused = ^{r_pos[FIX_W-1], r_pos[FRAC_BITS-1:0], r_vel[FIX_W-1]};

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl: a behavioural frame model feeds an expected-result queue,
// plus spot checks of the literal positions and velocities the game design calls for.
module tb_bird_motion_ctrl;
  import bird_pkg::*;

  localparam int SB_W = 28;

  logic        frame_clk;
  logic        Reset;
  logic        rdy;
  logic [7:0]  key;
  logic        collide;
  logic [9:0]  BirdX;
  logic [9:0]  BirdY;
  logic [9:0]  BirdW;
  logic [9:0]  BirdH;
  logic signed [13:0] vel_y;
  bird_state_t state;
  logic        flap_pulse;
  logic        gameover;

  bird_motion_ctrl dut (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .rdy        (rdy),
    .key        (key),
    .collide    (collide),
    .BirdX      (BirdX),
    .BirdY      (BirdY),
    .BirdW      (BirdW),
    .BirdH      (BirdH),
    .vel_y      (vel_y),
    .state      (state),
    .flap_pulse (flap_pulse),
    .gameover   (gameover)
  );

  // clock / reset
  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // counters and scoreboard
  int n_total = 0;
  int n_pass  = 0;
  int n_fp    = 0;
  int max_v   = -1000;
  logic [SB_W-1:0] exp_q[$];

  // behavioural frame model (pixel units x16)
  int m_y;
  int m_v;
  int m_st;
  bit m_prev;
  bit m_fp;
  bit m_go;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic void model_reset();
    m_y = 240 * 16;
    m_v = 0;
    m_st = 0;
    m_prev = 1'b0;
    m_fp = 1'b0;
    m_go = 1'b0;
  endfunction

  function automatic void model_step(input logic [7:0] k, input logic c, input logic r);
    bit hit;
    bit edge_k;
    int np;
    int nv;
    if (!r) begin
      m_fp = 1'b0;
      return;
    end
    hit = (k == 8'h1A) || (k == 8'hCC);
    edge_k = hit && !m_prev;
    m_prev = hit;
    m_fp = 1'b0;
    case (m_st)
      0: begin
        if (edge_k) begin
          m_st = 1;
          m_v = -96;
          m_fp = 1'b1;
        end
      end
      1, 2: begin
        np = m_y + m_v;
        nv = m_v + 8;
        if (nv > 128) nv = 128;
        if (m_st == 1 && edge_k && !c) begin
          nv = -96;
          m_fp = 1'b1;
        end
        if (m_st == 1 && c) m_st = 2;
        if (np >= 453 * 16) begin
          m_y = 453 * 16;
          m_v = 0;
          m_st = 3;
          m_go = 1'b1;
          m_fp = 1'b0;
        end else if (np < 0) begin
          m_y = 0;
          m_v = 0;
        end else begin
          m_y = np;
          m_v = nv;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [SB_W-1:0] model_pack();
    logic [9:0]  y10;
    logic [13:0] v14;
    logic [31:0] vv;
    y10 = 10'(m_y / 16);
    vv = m_v;
    v14 = vv[13:0];
    return {y10, v14, 2'(m_st), m_fp, m_go};
  endfunction

  // driver: one frame of stimulus, scoreboard push, then pop/compare after the edge
  task automatic step(input logic [7:0] k, input logic c, input logic r);
    logic [SB_W-1:0] obs;
    logic [SB_W-1:0] exp;
    key = k;
    collide = c;
    rdy = r;
    model_step(k, c, r);
    exp_q.push_back(model_pack());
    @(posedge frame_clk);
    #1;
    obs = {BirdY, vel_y, state, flap_pulse, gameover};
    exp = exp_q.pop_front();
    check("frame", int'(obs), int'(exp));
    if (flap_pulse) n_fp++;
    if (int'(vel_y) > max_v) max_v = int'(vel_y);
  endtask

  task automatic mid_frame_reset();
    #3;
    Reset = 1'b1;
    #1;
    model_reset();
    check("rst_y", int'(BirdY), 240);
    check("rst_vel", int'(vel_y), 0);
    check("rst_state", int'(state), int'(IDLE));
    check("rst_gameover", int'(gameover), 0);
    check("rst_flap", int'(flap_pulse), 0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    rdy = 1'b1;
    key = 8'h00;
    collide = 1'b0;
    model_reset();
    #2;
    check("reset_x", int'(BirdX), 100);
    check("reset_y", int'(BirdY), 240);
    check("reset_w", int'(BirdW), 86);
    check("reset_h", int'(BirdH), 26);
    check("reset_vel", int'(vel_y), 0);
    check("reset_state", int'(state), int'(IDLE));
    check("reset_gameover", int'(gameover), 0);
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;

    // idle: no keys, sprite stays at spawn
    for (int i = 0; i < 20; i++) step(8'h00, 1'b0, 1'b1);
    check("idle_y", int'(BirdY), 240);

    // single flap from IDLE
    step(8'h1A, 1'b0, 1'b1);
    check("flap_state", int'(state), int'(FLY));
    check("flap_vel", int'(vel_y), -96);
    check("flap_pulse", int'(flap_pulse), 1);
    step(8'h00, 1'b0, 1'b1);
    check("flap_y_next", int'(BirdY), 234);
    check("flap_vel_next", int'(vel_y), -88);
    check("flap_pulse_one", int'(flap_pulse), 0);

    // held key gives exactly one flap
    n_fp = 0;
    for (int i = 0; i < 15; i++) step(8'hCC, 1'b0, 1'b1);
    check("held_one_flap", n_fp, 1);
    check("held_vel", int'(vel_y), 16);

    // pause: key history frozen, nothing moves
    step(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(8'h1A, 1'b0, 1'b0);
    check("pause_state", int'(state), int'(FLY));
    step(8'h1A, 1'b0, 1'b1);
    check("resume_flap", int'(flap_pulse), 1);

    // free fall to the floor with velocity saturation
    max_v = -1000;
    for (int i = 0; i < 120; i++) begin
      step(8'h00, 1'b0, 1'b1);
      if (m_st == 3) break;
    end
    check("fall_vmax", max_v, 128);
    check("fall_y", int'(BirdY), 453);
    check("fall_vel", int'(vel_y), 0);
    check("fall_state", int'(state), int'(DEAD));
    check("fall_gameover", int'(gameover), 1);

    n_fp = 0;
    step(8'h1A, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b1);
    step(8'hCC, 1'b1, 1'b1);
    check("dead_no_flap", n_fp, 0);
    check("dead_y", int'(BirdY), 453);
    check("dead_gameover", int'(gameover), 1);

    // collision path: FLY -> DYING -> DEAD, flaps ignored
    mid_frame_reset();
    step(8'h1A, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b1);
    step(8'h1A, 1'b1, 1'b1);
    check("collide_state", int'(state), int'(DYING));
    check("collide_no_flap", int'(flap_pulse), 0);
    n_fp = 0;
    for (int i = 0; i < 150; i++) begin
      logic [7:0] k;
      k = (i % 2 == 0) ? 8'h00 : (($urandom_range(0, 1) == 1) ? 8'h1A : 8'hCC);
      step(k, 1'($urandom_range(0, 1)), 1'b1);
      if (m_st == 3) break;
    end
    check("dying_no_flap", n_fp, 0);
    check("dying_y", int'(BirdY), 453);
    check("dying_state", int'(state), int'(DEAD));

    // ceiling clamp with repeated flaps
    mid_frame_reset();
    for (int i = 0; i < 100; i++) begin
      step((i % 2 == 0) ? 8'h1A : 8'h00, 1'b0, 1'b1);
      if (m_st == 1 && m_y == 0) break;
    end
    check("ceil_y", int'(BirdY), 0);
    check("ceil_vel", int'(vel_y), 0);
    check("ceil_state", int'(state), int'(FLY));
    step(8'h00, 1'b0, 1'b1);
    check("ceil_after_y", int'(BirdY), 0);
    check("ceil_after_vel", int'(vel_y), 8);
    check("end_x", int'(BirdX), 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
